aes_word_io: RTL and testbench

AES_WORD_IO -- requirements
Module: aes_word_io

---
 rtl/aes_word_io_if.sv | 38 +++
 rtl/aes_word_io.sv | 147 ++++++++++++++
 tb/tb_aes_word_io.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_word_io_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aes_word_io_if
//  Description : Bundles the aes_word_io signals. The slave modport is the
//                word I/O block. The master modport is everything around it:
//                the host on the word side and the AES core on the block side.
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_word_io_if;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic         in_keysel;
    logic [127:0] aes_key;
    logic [127:0] aes_data;
    logic         aes_start;
    logic         aes_done;
    logic [127:0] aes_out;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         busy;

    modport master (
        output in_valid, in_data, in_keysel, aes_done, aes_out, out_ready,
        input  in_ready, aes_key, aes_data, aes_start, out_valid, out_data,
               out_last, busy
    );

    modport slave (
        input  in_valid, in_data, in_keysel, aes_done, aes_out, out_ready,
        output in_ready, aes_key, aes_data, aes_start, out_valid, out_data,
               out_last, busy
    );
endinterface
`default_nettype wire

// File: rtl/aes_word_io.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : aes_word_io
//  Description : 32-bit word front end for a 128-bit AES core. The block
//                gathers key and data words from the host, starts the core,
//                captures the ciphertext, and returns it as four words.
//                Optional macro AES_KEY_REUSE_EN: when it is defined, a block
//                whose first word has in_keysel=0 carries only four data words
//                and reuses the key that is already loaded.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_word_io (
    input  logic          clk,
    input  logic          rst,
    aes_word_io_if.slave  bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_CAPT  = 3'd4;
    localparam logic [2:0] S_SEND  = 3'd5;

    logic [2:0]   state_q, state_d;
    logic [2:0]   wcnt_q,  wcnt_d;
    logic [1:0]   ocnt_q,  ocnt_d;
    logic [127:0] key_q,   key_d;
    logic [127:0] data_q,  data_d;
    logic [127:0] obuf_q,  obuf_d;

    logic         ready;
    logic         accept;
    logic [2:0]   first_idx;
    logic [2:0]   widx;
    logic [1:0]   wsel;
    logic [1:0]   osel;

    // A key-less block skips the four key slots. It starts at data word 0,
    // which is slot 4 of the 8-slot block.
`ifdef AES_KEY_REUSE_EN
    assign first_idx = bus.in_keysel ? 3'd0 : 3'd4;
`else
    assign first_idx = 3'd0;
`endif

    // Input handshake. The block takes no words while reset is held.
    assign ready  = rst && ((state_q == S_IDLE) || (state_q == S_LOAD));
    assign accept = bus.in_valid && ready;
    assign widx   = (state_q == S_IDLE) ? first_idx : wcnt_q;
    assign wsel   = 2'd3 - widx[1:0];
    assign osel   = 2'd3 - ocnt_q;

    // Next-state logic: word loading, core handshake and output sequencing.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        ocnt_d  = ocnt_q;
        key_d   = key_q;
        data_d  = data_q;
        obuf_d  = obuf_q;

        // The most significant word comes first, so slot 0 of each group
        // lands in bits [127:96].
        if (accept) begin
            if (!widx[2]) begin
                key_d[{wsel, 5'd0} +: 32] = bus.in_data;
            end else begin
                data_d[{wsel, 5'd0} +: 32] = bus.in_data;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    wcnt_d  = widx + 3'd1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    if (widx == 3'd7) begin
                        wcnt_d  = 3'd0;
                        state_d = S_START;
                    end else begin
                        wcnt_d  = widx + 3'd1;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.aes_done) begin
                    state_d = S_CAPT;
                end
            end
            S_CAPT: begin
                // The core presents its result one cycle after aes_done.
                obuf_d  = bus.aes_out;
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.out_ready) begin
                    if (ocnt_q == 2'd3) begin
                        ocnt_d  = 2'd0;
                        state_d = S_IDLE;
                    end else begin
                        ocnt_d  = ocnt_q + 2'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers. Reset is asynchronous and abandons any partial block.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= 3'd0;
            ocnt_q  <= 2'd0;
            key_q   <= '0;
            data_q  <= '0;
            obuf_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            ocnt_q  <= ocnt_d;
            key_q   <= key_d;
            data_q  <= data_d;
            obuf_q  <= obuf_d;
        end
    end

    assign bus.in_ready  = ready;
    assign bus.aes_key   = key_q;
    assign bus.aes_data  = data_q;
    assign bus.aes_start = (state_q == S_START);
    assign bus.out_valid = (state_q == S_SEND);
    assign bus.out_data  = obuf_q[{osel, 5'd0} +: 32];
    assign bus.out_last  = (state_q == S_SEND) && (ocnt_q == 2'd3);
    assign bus.busy      = (state_q != S_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_aes_word_io.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_aes_word_io
//  Description : Self-checking bench for aes_word_io. It plays both the host
//                and a behavioural AES core, and checks the output words
//                against a scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_aes_word_io;
    localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam int           CORE_LAT = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    aes_word_io_if bus ();
    aes_word_io dut (.clk(clk), .rst(rst), .bus(bus));

    logic core_done  = 1'b0;
    logic stray_done = 1'b0;
    assign bus.aes_done = core_done | stray_done;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct { logic [31:0] data; logic last; } ow_t;
    ow_t sb[$];

    typedef struct {
        logic [127:0] key;
        logic [127:0] data;
        logic         keysel;
        int           gap;
        int           rdy_mode;
        logic         stray;
        logic [127:0] ek;    // key the core should see
        logic [127:0] exp;   // expected ciphertext
    } vec_t;
    vec_t vecs[5];

    int           core_cnt = 0;
    logic [127:0] core_k, core_d;
    int           starts   = 0;
    logic         hold_pend = 1'b0;
    logic [31:0]  hold_word;
    int           rdy_mode = 0;
    int           rdy_ph   = 0;
    logic         acc;
    logic [127:0] cur_key;

    // Core model: the FIPS-197 pair maps to its known ciphertext. Any other
    // pair maps to a fixed mixing function. That is enough to expose word
    // assembly faults.
    function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] d);
        if (k == FIPS_K && d == FIPS_P) return FIPS_C;
        return k ^ {d[63:0], d[127:64]} ^ 128'h5a5a_5a5a_3c3c_3c3c_a5a5_a5a5_c3c3_c3c3;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock cycle. The first part samples settled values before the edge.
    // The second part, after the edge, drives the core and out_ready.
    task automatic tick();
        #1;
        acc = bus.in_valid && bus.in_ready;
        if (bus.aes_start) begin
            starts++;
            core_k   = bus.aes_key;
            core_d   = bus.aes_data;
            core_cnt = CORE_LAT;
        end
        if (bus.out_valid) begin
            chk("busy_in_send", {127'd0, bus.busy}, 128'd1);
            if (hold_pend) chk("held_word", {96'd0, bus.out_data}, {96'd0, hold_word});
            if (bus.out_ready) begin
                hold_pend = 1'b0;
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got %h want none", bus.out_data);
                end else begin
                    ow_t e;
                    e = sb.pop_front();
                    chk("out_data", {96'd0, bus.out_data}, {96'd0, e.data});
                    chk("out_last", {127'd0, bus.out_last}, {127'd0, e.last});
                end
            end else begin
                hold_pend = 1'b1;
                hold_word = bus.out_data;
            end
        end
        @(posedge clk);
        #1;
        if (core_done) begin
            core_done   = 1'b0;
            bus.aes_out = cipher(core_k, core_d);
        end else begin
            bus.aes_out = {$urandom, $urandom, $urandom, $urandom};
        end
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) core_done = 1'b1;
        end
        rdy_ph++;
        bus.out_ready = (rdy_mode == 0) ? 1'b1 : ((rdy_ph % 3) == 0);
    endtask

    task automatic drive_word(input logic [31:0] w, input logic ks);
        int t;
        bus.in_valid  = 1'b1;
        bus.in_data   = w;
        bus.in_keysel = ks;
        t = 0;
        do begin
            tick();
            t++;
        end while (!acc && t < 50);
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL word_accept_timeout: got none want accept");
        end
    endtask

    task automatic send_block(input vec_t v);
        logic [31:0] w[8];
        int          nw;
        int          base;
        for (int k = 0; k < 4; k++) begin
            w[k]     = v.key[127-32*k -: 32];
            w[k + 4] = v.data[127-32*k -: 32];
        end
        nw = 8;
`ifdef AES_KEY_REUSE_EN
        if (!v.keysel) begin
            nw = 4;
            for (int k = 0; k < 4; k++) w[k] = w[k + 4];
        end
`endif
        for (int k = 0; k < 4; k++) sb.push_back('{v.exp[127-32*k -: 32], (k == 3)});
        rdy_mode = v.rdy_mode;
        base     = starts;
        for (int i = 0; i < nw; i++) begin
            if (v.stray && i == 2) stray_done = 1'b1;
            // Only the first word's keysel counts, so the later ones carry the opposite value.
            drive_word(w[i], (i == 0) ? v.keysel : ~v.keysel);
            stray_done = 1'b0;
            if (i != nw - 1 && v.gap > 0) begin
                bus.in_valid = 1'b0;
                repeat (v.gap) tick();
            end
        end
        chk("no_early_start", starts, base);
        bus.in_valid = 1'b0;
        #1;
        chk("start_latency", {127'd0, bus.aes_start}, 128'd1);
        chk("aes_key", bus.aes_key, v.ek);
        chk("aes_data", bus.aes_data, v.data);
        if (v.stray) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hdeadbeef;
            repeat (3) begin
                tick();
                chk("ready_low_in_wait", {127'd0, bus.in_ready}, 128'd0);
            end
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        do begin
            tick();
            t++;
        end while ((bus.busy || sb.size() != 0) && t < 300);
        if (bus.busy || sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL block_timeout: got busy=%0d pending=%0d want idle", bus.busy, sb.size());
        end
        chk("ready_after_block", {127'd0, bus.in_ready}, 128'd1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_keysel = 1'b0;
        bus.aes_out   = '0;
        bus.out_ready = 1'b1;

        vecs[0] = '{FIPS_K, FIPS_P, 1'b1, 0, 0, 1'b0, '0, '0};
        vecs[1] = '{FIPS_K, FIPS_P, 1'b1, 0, 1, 1'b0, '0, '0};
        vecs[2] = '{128'hffeeddccbbaa99887766554433221100, FIPS_P, 1'b0, 1, 0, 1'b0, '0, '0};
        vecs[3] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'h3243f6a8885a308d313198a2e0370734, 1'b1, 2, 1, 1'b1, '0, '0};
        vecs[4] = '{128'h0f0e0d0c0b0a09080706050403020100,
                    128'hcafef00d12345678deadbeef87654321, 1'b0, 0, 0, 1'b1, '0, '0};
        cur_key = '0;
        for (int i = 0; i < 5; i++) begin
`ifdef AES_KEY_REUSE_EN
            if (vecs[i].keysel) cur_key = vecs[i].key;
`else
            cur_key = vecs[i].key;
`endif
            vecs[i].ek  = cur_key;
            vecs[i].exp = cipher(cur_key, vecs[i].data);
        end

        // Reset state, with a word offered while reset is held.
        bus.in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready",  {127'd0, bus.in_ready},  128'd0);
        chk("rst_busy",      {127'd0, bus.busy},      128'd0);
        chk("rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rst_out_last",  {127'd0, bus.out_last},  128'd0);
        chk("rst_aes_start", {127'd0, bus.aes_start}, 128'd0);
        chk("rst_aes_key",   bus.aes_key,  128'd0);
        chk("rst_aes_data",  bus.aes_data, 128'd0);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("ready_after_rst", {127'd0, bus.in_ready}, 128'd1);

        for (int i = 0; i < 5; i++) begin
            send_block(vecs[i]);
            wait_idle();
        end

        // Reset after word 5 of a block, then a clean FIPS block.
        rdy_mode = 0;
        for (int k = 0; k < 5; k++) begin
            logic [255:0] blk;
            blk = {128'h11111111222222223333333344444444, 128'h55555555666666667777777788888888};
            drive_word(blk[255-32*k -: 32], 1'b1);
        end
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", {127'd0, bus.in_ready}, 128'd0);
        chk("midrst_busy",     {127'd0, bus.busy},     128'd0);
        chk("midrst_aes_key",  bus.aes_key,  128'd0);
        chk("midrst_aes_data", bus.aes_data, 128'd0);
        chk("midrst_start",    {127'd0, bus.aes_start}, 128'd0);
        chk("midrst_out_valid", {127'd0, bus.out_valid}, 128'd0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("ready_after_midrst", {127'd0, bus.in_ready}, 128'd1);
        send_block('{FIPS_K, FIPS_P, 1'b1, 0, 0, 1'b0, FIPS_K, FIPS_C});
        wait_idle();

        chk("start_count", starts, 6);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire
